// File: rtl/ddr_wr_burst_ctrl.sv
// rtl/ddr_wr_burst_ctrl.sv - AXI4 write burst master packing prefetch FIFO words into fixed-length frame bursts
// Optional DDR_WR_PINGPONG_EN: alternate frames between two buffers spaced FRAME_STRIDE apart.
module ddr_wr_burst_ctrl #(
  parameter int          ADDR_WIDTH   = 28,
  parameter int          DATA_WIDTH   = 256,
  parameter int          BURST_LEN    = 16,
  parameter int          FRAME_BEATS  = 115200,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned FRAME_STRIDE = 32'h0100_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  output logic                    fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    frame_done,
  output logic                    buf_idx,
  output logic                    wr_err
);

  localparam int BL_W = $clog2(FRAME_BEATS + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A  = ADDR_WIDTH'(FRAME_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] INC_A     = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
  localparam logic [BL_W-1:0]       FRAME_L   = BL_W'(FRAME_BEATS);
  localparam logic [BL_W-1:0]       BURST_L   = BL_W'(BURST_LEN);
  localparam logic [7:0]            LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t                  state_q, state_d;
  logic                    pend_q, pend_d;
  logic                    buf_idx_q, buf_idx_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [BL_W-1:0]         beats_left_q, beats_left_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    awvalid_q, awvalid_d;
  logic                    frame_done_q, frame_done_d;
  logic                    wr_err_q, wr_err_d;
  logic                    buf_idx_nx;
  logic                    w_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      buf_idx_q    <= 1'b0;
      awaddr_q     <= BASE_A;
      beats_left_q <= '0;
      beat_cnt_q   <= '0;
      awvalid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      buf_idx_q    <= buf_idx_d;
      awaddr_q     <= awaddr_d;
      beats_left_q <= beats_left_d;
      beat_cnt_q   <= beat_cnt_d;
      awvalid_q    <= awvalid_d;
      frame_done_q <= frame_done_d;
      wr_err_q     <= wr_err_d;
    end
  end

  assign wvalid     = (state_q == S_W) && fifo_rd_vld;
  assign w_fire     = wvalid && wready;
  assign wlast      = (state_q == S_W) && (beat_cnt_q == LAST_BEAT);
  assign fifo_rd_en = w_fire;
  assign wdata      = fifo_rd_data;
  assign wstrb      = '1;
  assign bready     = (state_q == S_B);
  assign awvalid    = awvalid_q;
  assign awaddr     = awaddr_q;
  assign awlen      = LAST_BEAT;
  assign frame_done = frame_done_q;
  assign buf_idx    = buf_idx_q;
  assign wr_err     = wr_err_q;

  always_comb begin
`ifdef DDR_WR_PINGPONG_EN
    buf_idx_nx = ~buf_idx_q;
`else
    buf_idx_nx = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q | frame_start;
    buf_idx_d    = buf_idx_q;
    awaddr_d     = awaddr_q;
    beats_left_d = beats_left_q;
    beat_cnt_d   = beat_cnt_q;
    awvalid_d    = awvalid_q;
    frame_done_d = 1'b0;
    wr_err_d     = wr_err_q;
    case (state_q)
      S_IDLE: begin
        // A pending frame_start wins over leftover beats, abandoning the old frame.
        if (pend_q) begin
          pend_d       = frame_start;
          buf_idx_d    = buf_idx_nx;
          awaddr_d     = BASE_A + (buf_idx_nx ? STRIDE_A : '0);
          beats_left_d = FRAME_L;
          awvalid_d    = 1'b1;
          state_d      = S_AW;
        end else if (beats_left_q != '0) begin
          awvalid_d = 1'b1;
          state_d   = S_AW;
        end
      end
      S_AW: begin
        if (awvalid_q && awready) begin
          awvalid_d  = 1'b0;
          beat_cnt_d = '0;
          state_d    = S_W;
        end
      end
      S_W: begin
        if (w_fire) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (wlast) state_d = S_B;
        end
      end
      S_B: begin
        if (bvalid) begin
          if (bresp != 2'b00) wr_err_d = 1'b1;
          beats_left_d = beats_left_q - BURST_L;
          awaddr_d     = awaddr_q + INC_A;
          frame_done_d = (beats_left_q == BURST_L);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// tb/tb_ddr_wr_burst_ctrl.sv - self-checking bench for ddr_wr_burst_ctrl
// Scenario table plus hand sequences; AW/W scoreboards filled as frames are queued.
`timescale 1ns/1ps
module tb_ddr_wr_burst_ctrl;
  localparam int AW = 28;
  localparam int DW = 256;
  localparam int BL = 4;
  localparam int FB = 8;
  localparam int unsigned STRIDE = 32'h1000;
`ifdef DDR_WR_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, frame_start, fifo_rd_vld, fifo_rd_en;
  logic [DW-1:0]   fifo_rd_data, wdata;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp;
  logic            frame_done, buf_idx, wr_err;

  ddr_wr_burst_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .FRAME_BEATS(FB),
    .BASE_ADDR(0), .FRAME_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .frame_done(frame_done), .buf_idx(buf_idx), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic bidx; } aw_t;
  typedef struct { logic [DW-1:0] data; logic last; } w_t;
  typedef struct {
    string name; int nframes; int stall_after; int stall_len; int err_burst;
    bit rand_bp; int exp_done; bit exp_err;
  } scen_t;

  aw_t           aw_exp[$];
  w_t            w_exp[$];
  logic [DW-1:0] fifo_q[$];
  scen_t         tbl[5];

  int n_tests, n_fail, cyc, start_cyc, done_cnt, b_cnt, beats_frame;
  int stall_after, stall_left, err_burst;
  bit rand_bp, arm_lat, pop_now, prev_aw_stall, stall;
  logic [AW-1:0] prev_awaddr;
  logic buf_m;
  string cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", cur, name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", cur, name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_fifo();
    fifo_rd_vld  = (fifo_q.size() != 0) && !stall;
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic monitor();
    cyc++;
    pop_now = fifo_rd_en;
    if (prev_aw_stall) begin
      check("aw_hold_valid", 64'(awvalid), 64'd1);
      check("aw_hold_addr", 64'(awaddr), 64'(prev_awaddr));
    end
    prev_aw_stall = awvalid && !awready;
    prev_awaddr   = awaddr;
    if (arm_lat && awvalid) begin
      check("aw_latency", 64'(cyc - start_cyc), 64'd2);
      arm_lat = 1'b0;
    end
    check("rd_en_eq_wfire", 64'(fifo_rd_en), 64'(wvalid && wready));
    if (!fifo_rd_vld) check("wvalid_no_data", 64'(wvalid), 64'd0);
    if (awvalid && awready) begin
      check("aw_expected", 64'(aw_exp.size() != 0), 64'd1);
      if (aw_exp.size() != 0) begin
        aw_t e;
        e = aw_exp.pop_front();
        check("awaddr", 64'(awaddr), 64'(e.addr));
        check("awlen", 64'(awlen), 64'(BL - 1));
        check("buf_idx", 64'(buf_idx), 64'(e.bidx));
      end
    end
    if (wvalid && wready) begin
      check("w_expected", 64'(w_exp.size() != 0), 64'd1);
      if (w_exp.size() != 0) begin
        w_t e;
        e = w_exp.pop_front();
        check_data("wdata", wdata, e.data);
        check("wlast", 64'(wlast), 64'(e.last));
        check("wstrb", 64'(wstrb), 64'(32'hFFFF_FFFF));
      end
    end
    if (bvalid && bready) b_cnt++;
    if (frame_done) done_cnt++;
  endtask

  task automatic cycle();
    logic [DW-1:0] dummy;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (pop_now && fifo_q.size() != 0) begin
      dummy = fifo_q.pop_front();
      beats_frame++;
    end
    frame_start = 1'b0;
    if (stall_left > 0 && beats_frame == stall_after) begin
      stall = 1'b1;
      stall_left--;
    end else begin
      stall = 1'b0;
    end
    awready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    wready  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bvalid  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
    drive_fifo();
  endtask

  task automatic push_frame(input int nb);
    logic [AW-1:0] base;
    if (PP) buf_m = ~buf_m;
    base = buf_m ? AW'(STRIDE) : '0;
    for (int b = 0; b < nb; b++) begin
      aw_t a;
      a.addr = base + AW'(b * BL * DW / 8);
      a.bidx = buf_m;
      aw_exp.push_back(a);
      for (int i = 0; i < BL; i++) begin
        w_t w;
        w.data = rand_word();
        w.last = (i == BL - 1);
        w_exp.push_back(w);
        fifo_q.push_back(w.data);
      end
    end
    drive_fifo();
  endtask

  task automatic start_frame(input bit arm);
    frame_start = 1'b1;
    beats_frame = 0;
    start_cyc   = cyc + 1;
    arm_lat     = arm;
    cycle();
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      cycle();
      n++;
    end
    check("frame_done_seen", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats_frame < target && n < 400) begin
      cycle();
      n++;
    end
    check("beats_reached", 64'(beats_frame >= target), 64'd1);
  endtask

  task automatic end_checks(input int exp_done, input bit exp_err);
    repeat (4) cycle();
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("aw_left", 64'(aw_exp.size()), 64'd0);
    check("w_left", 64'(w_exp.size()), 64'd0);
    check("fifo_left", 64'(fifo_q.size()), 64'd0);
    check("wr_err", 64'(wr_err), 64'(exp_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_start = 1'b0; stall = 1'b0; stall_left = 0; stall_after = -1;
    rand_bp = 1'b0; err_burst = -1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    aw_exp.delete(); w_exp.delete(); fifo_q.delete();
    buf_m = 1'b0; done_cnt = 0; b_cnt = 0; beats_frame = 0;
    arm_lat = 1'b0; prev_aw_stall = 1'b0;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_wr_err", 64'(wr_err), 64'd0);
    check("rst_buf_idx", 64'(buf_idx), 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; start_cyc = 0;
    tbl[0] = '{"basic",        1, -1, 0, -1, 1'b0, 1, 1'b0};
    tbl[1] = '{"fifo_stall",   1,  2, 3, -1, 1'b0, 1, 1'b0};
    tbl[2] = '{"bresp_err",    2, -1, 0,  1, 1'b0, 2, 1'b1};
    tbl[3] = '{"backpressure", 2, -1, 0, -1, 1'b1, 2, 1'b0};
    tbl[4] = '{"stall_bp",     1,  5, 2, -1, 1'b1, 1, 1'b0};

    cur = "idle";
    do_reset();
    fifo_q.push_back(rand_word());
    fifo_q.push_back(rand_word());
    drive_fifo();
    repeat (20) begin
      cycle();
      check("idle_awvalid", 64'(awvalid), 64'd0);
      check("idle_rd_en", 64'(fifo_rd_en), 64'd0);
    end

    for (int s = 0; s < 5; s++) begin
      cur = tbl[s].name;
      do_reset();
      stall_after = tbl[s].stall_after;
      stall_left  = tbl[s].stall_len;
      err_burst   = tbl[s].err_burst;
      rand_bp     = tbl[s].rand_bp;
      for (int f = 0; f < tbl[s].nframes; f++) begin
        push_frame(FB / BL);
        start_frame(1'b1);
        wait_done(f + 1);
      end
      end_checks(tbl[s].exp_done, tbl[s].exp_err);
    end

    cur = "abort";
    do_reset();
    push_frame(1);
    start_frame(1'b1);
    wait_beats(1);
    push_frame(FB / BL);
    start_frame(1'b0);
    wait_done(1);
    end_checks(1, 1'b0);

    cur = "start_on_last_b";
    do_reset();
    push_frame(FB / BL);
    start_frame(1'b1);
    wait_beats(FB);
    push_frame(FB / BL);
    start_frame(1'b0);
    wait_done(2);
    end_checks(2, 1'b0);

    cur = "async_reset";
    do_reset();
    push_frame(FB / BL);
    start_frame(1'b1);
    wait_beats(1);
    check("pre_rst_wvalid", 64'(wvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_awvalid", 64'(awvalid), 64'd0);
    check("arst_wvalid", 64'(wvalid), 64'd0);
    check("arst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("arst_bready", 64'(bready), 64'd0);
    check("arst_awaddr", 64'(awaddr), 64'd0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
